// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes rx, validates the start bit, shifts data in LSB first,
// checks optional parity and the stop bit, and presents each word on a valid/ready handshake.
module uart_rx_deserializer #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic             ODD      = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data, input logic pbit);
      return (^data) ^ pbit ^ ODD;
   endfunction

   logic                 rx_meta_q, rx_s_q;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_pend_q, perr_pend_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 parity_err_q, parity_err_d;
   logic                 overrun_q, overrun_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shift_d      = shift_q;
      perr_pend_d  = perr_pend_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = rx_valid_q;
      frame_err_d  = frame_err_q;
      parity_err_d = parity_err_q;
      overrun_d    = 1'b0;

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      if (sample_tick) begin
         cnt_d = cnt_q + 1'b1;
         case (state_q)
            S_IDLE: begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d = S_START;
               end
            end
            S_START: begin
               // A start bit that is high again at its midpoint was a glitch.
               if (cnt_q == CNT_MID) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = rx_s_q ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                  idx_d   = idx_q + 1'b1;
                  if (idx_q == IDX_LAST) begin
                     cnt_d   = '0;
                     state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                  end
               end
            end
            S_PARITY: begin
               if (cnt_q == CNT_LAST) begin
                  perr_pend_d = parity_mismatch(shift_q, rx_s_q);
                  cnt_d       = '0;
                  state_d     = S_STOP;
               end
            end
            S_STOP: begin
               // Leave at mid stop bit so a directly following start bit is caught.
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
                  if (!rx_valid_q || rx_ready) begin
                     rx_data_d    = shift_q;
                     frame_err_d  = ~rx_s_q;
                     parity_err_d = (PARITY_EN != 0) ? perr_pend_q : 1'b0;
                     rx_valid_d   = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            end
            default: begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         perr_pend_q  <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         perr_pend_q  <= perr_pend_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: an 8N1 instance (index 0) and an 8E1 instance (index 1),
// tick every 4 clk, frames driven bit by bit and checked against hand-computed values.
module tb_uart_rx_deserializer;

   localparam int OS      = 16;
   localparam int TICK_P  = 4;
   localparam int BIT_CLK = OS * TICK_P;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       tick;
   logic       rx_w   [2];
   logic       rdy_w  [2];
   logic [7:0] data_w [2];
   logic       vld_w  [2];
   logic       ferr_w [2];
   logic       perr_w [2];
   logic       ovr_w  [2];
   logic       busy_w [2];

   uart_rx_deserializer #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_n (
      .clk(clk), .reset(reset), .sample_tick(tick), .rx(rx_w[0]),
      .rx_data(data_w[0]), .rx_valid(vld_w[0]), .rx_ready(rdy_w[0]),
      .frame_err(ferr_w[0]), .parity_err(perr_w[0]), .overrun(ovr_w[0]), .busy(busy_w[0]));

   uart_rx_deserializer #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_e (
      .clk(clk), .reset(reset), .sample_tick(tick), .rx(rx_w[1]),
      .rx_data(data_w[1]), .rx_valid(vld_w[1]), .rx_ready(rdy_w[1]),
      .frame_err(ferr_w[1]), .parity_err(perr_w[1]), .overrun(ovr_w[1]), .busy(busy_w[1]));

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Tick high for one clk in every four, changing on the falling edge.
   initial begin
      int tcnt;
      tcnt = 0;
      tick = 1'b0;
      forever begin
         @(negedge clk);
         tcnt = (tcnt + 1) % TICK_P;
         tick = (tcnt == TICK_P - 1);
      end
   end

   // Output monitor: records each rx_valid rise and counts high cycles of rx_valid and overrun.
   int         rise_cnt  [2] = '{0, 0};
   int         rise_cyc  [2] = '{0, 0};
   int         vld_cyc   [2] = '{0, 0};
   int         ovr_cyc   [2] = '{0, 0};
   logic [7:0] rise_data [2] = '{8'h00, 8'h00};
   logic       rise_ferr [2] = '{1'b0, 1'b0};
   logic       rise_perr [2] = '{1'b0, 1'b0};
   logic       prev_vld  [2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         prev_vld[d] <= vld_w[d];
         if (vld_w[d] === 1'b1 && prev_vld[d] !== 1'b1) begin
            rise_cnt[d]  <= rise_cnt[d] + 1;
            rise_cyc[d]  <= cyc;
            rise_data[d] <= data_w[d];
            rise_ferr[d] <= ferr_w[d];
            rise_perr[d] <= perr_w[d];
         end
         if (vld_w[d] === 1'b1) vld_cyc[d] <= vld_cyc[d] + 1;
         if (ovr_w[d] === 1'b1) ovr_cyc[d] <= ovr_cyc[d] + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic align_to_tick();
      do @(posedge clk); while (tick !== 1'b1);
      @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input logic [7:0] data, input logic par_bit,
                             input logic stop_bit, input int idle_bits, output int start_c);
      align_to_tick();
      start_c = cyc;
      rx_w[sel] = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_w[sel] = data[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      if (sel == 1) begin
         rx_w[sel] = par_bit;
         repeat (BIT_CLK) @(negedge clk);
      end
      rx_w[sel] = stop_bit;
      repeat (BIT_CLK) @(negedge clk);
      rx_w[sel] = 1'b1;
      repeat (BIT_CLK * idle_bits) @(negedge clk);
   endtask

   // First tick after the edge, half a bit to mid start, then data (+parity) and stop samples.
   function automatic int exp_latency(input int sel);
      return TICK_P + TICK_P * (OS / 2) + BIT_CLK * (8 + sel + 1);
   endfunction

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic       par_bit;
      logic       stop_bit;
      logic [7:0] exp_data;
      logic       exp_ferr;
      logic       exp_perr;
   } vec_t;

   vec_t vecs[9];
   logic busy_trace[41];

   initial begin
      int s, r0, v0, o0, sc;

      vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
      vecs[2] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[4] = '{0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[5] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
      vecs[6] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
      vecs[7] = '{1, 8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1};
      vecs[8] = '{1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

      reset = 1'b1;
      rx_w[0] = 1'b1;  rx_w[1] = 1'b1;
      rdy_w[0] = 1'b1; rdy_w[1] = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset dut%0d rx_data", d), int'(data_w[d]), 0);
         check($sformatf("reset dut%0d rx_valid", d), int'(vld_w[d]), 0);
         check($sformatf("reset dut%0d frame_err", d), int'(ferr_w[d]), 0);
         check($sformatf("reset dut%0d parity_err", d), int'(perr_w[d]), 0);
         check($sformatf("reset dut%0d overrun", d), int'(ovr_w[d]), 0);
         check($sformatf("reset dut%0d busy", d), int'(busy_w[d]), 0);
      end

      for (int v = 0; v < 9; v++) begin
         s  = vecs[v].sel;
         r0 = rise_cnt[s];
         v0 = vld_cyc[s];
         send_frame(s, vecs[v].data, vecs[v].par_bit, vecs[v].stop_bit, 2, sc);
         check($sformatf("v%0d valid count", v), rise_cnt[s] - r0, 1);
         check($sformatf("v%0d rx_data", v), int'(rise_data[s]), int'(vecs[v].exp_data));
         check($sformatf("v%0d frame_err", v), int'(rise_ferr[s]), int'(vecs[v].exp_ferr));
         check($sformatf("v%0d parity_err", v), int'(rise_perr[s]), int'(vecs[v].exp_perr));
         check($sformatf("v%0d latency", v), rise_cyc[s] - sc, exp_latency(s));
         check($sformatf("v%0d valid width", v), vld_cyc[s] - v0, 1);
      end

      // Start glitch: low for 6 ticks, rejected at the 8th tick after detection.
      r0 = rise_cnt[0];
      o0 = ovr_cyc[0];
      align_to_tick();
      rx_w[0] = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (j == 6 * TICK_P) rx_w[0] = 1'b1;
         busy_trace[j] = busy_w[0];
      end
      check("glitch busy before detect", int'(busy_trace[3]), 0);
      check("glitch busy after detect", int'(busy_trace[4]), 1);
      check("glitch busy before mid", int'(busy_trace[35]), 1);
      check("glitch busy after mid", int'(busy_trace[36]), 0);
      repeat (BIT_CLK) @(negedge clk);
      check("glitch no valid", rise_cnt[0] - r0, 0);
      check("glitch rx_valid", int'(vld_w[0]), 0);
      check("glitch no overrun", ovr_cyc[0] - o0, 0);

      // Overrun: consumer stalled, two frames back to back.
      rdy_w[0] = 1'b0;
      r0 = rise_cnt[0];
      o0 = ovr_cyc[0];
      send_frame(0, 8'h11, 1'b0, 1'b1, 0, sc);
      send_frame(0, 8'h22, 1'b0, 1'b1, 2, sc);
      check("overrun valid count", rise_cnt[0] - r0, 1);
      check("overrun rx_data kept", int'(data_w[0]), 'h11);
      check("overrun rx_valid held", int'(vld_w[0]), 1);
      check("overrun pulse width", ovr_cyc[0] - o0, 1);
      rdy_w[0] = 1'b1;
      @(negedge clk);
      check("accept drops rx_valid", int'(vld_w[0]), 0);
      check("accept keeps rx_data", int'(data_w[0]), 'h11);

      // Reset in the middle of data bit 4 of 0x5A, then a clean 0x5A.
      r0 = rise_cnt[0];
      align_to_tick();
      rx_w[0] = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_w[0] = sc[0] ^ sc[0] ^ 1'(8'h5A >> i);
         repeat (BIT_CLK) @(negedge clk);
      end
      rx_w[0] = 1'b1;
      repeat (BIT_CLK / 2) @(negedge clk);
      check("busy mid-frame", int'(busy_w[0]), 1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("mid reset busy", int'(busy_w[0]), 0);
      check("mid reset rx_data", int'(data_w[0]), 0);
      check("mid reset rx_valid", int'(vld_w[0]), 0);
      check("mid reset overrun", int'(ovr_w[0]), 0);
      repeat (4 * BIT_CLK) @(negedge clk);
      check("aborted frame no valid", rise_cnt[0] - r0, 0);
      send_frame(0, 8'h5A, 1'b0, 1'b1, 2, sc);
      check("after reset valid count", rise_cnt[0] - r0, 1);
      check("after reset rx_data", int'(rise_data[0]), 'h5A);
      check("after reset frame_err", int'(rise_ferr[0]), 0);
      check("after reset latency", rise_cyc[0] - sc, exp_latency(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- UART receive front end. Oversamples the asynchronous serial line using the one-cycle tick from the UART tick counter's compare flag, detects and validates start bits, and shifts in data bits LSB first.
- Checks optional parity and the stop bit.
- Delivers each byte on a valid/ready handshake to the downstream consumer (RX FIFO or register interface).

Parameters:
- DATA_BITS, 8, data bits per frame; legal values 5..9.
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be an even power of two, at least 4.
- PARITY_EN, 0, 1 = one parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- sample_tick  in  1  one-clk pulse at OVERSAMPLE x baud; the only timebase.
- rx  in  1  asynchronous serial input; idle high.
- rx_data  out  DATA_BITS  received word; bit 0 = first bit received.
- rx_valid  out  1  rx_data and the error flags are valid; held until accepted.
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready.
- frame_err  out  1  stop bit sampled low; qualified by rx_valid.
- parity_err  out  1  parity mismatch; qualified by rx_valid; always 0 when PARITY_EN = 0.
- overrun  out  1  one-clk pulse when a completed frame is discarded.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Synchronizer: rx passes through 2 flops (rx_s). Both flops reset to 1. All decisions use rx_s only.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0. FSM = IDLE; sample counter, bit index and shift register = 0.
- Reset mid-frame: the partial frame is discarded silently and no flag is raised.
- Sample counter: width log2(OVERSAMPLE). It increments only on cycles with sample_tick=1 and is cleared on every state transition.
- The FSM never advances without sample_tick.
- FSM states:
  - IDLE: on a tick with rx_s=0 -> START, counter=0.
  - START: on the tick where counter = OVERSAMPLE/2-1 (mid start bit), re-sample rx_s.
    - rx_s=0 -> DATA, bit index=0.
    - rx_s=1 -> IDLE (glitch rejected; no flags raised).
  - DATA: on the tick where counter = OVERSAMPLE-1 (one full bit later, i.e. mid-bit):
    - Shift rx_s in at the MSB end of the shift register (shift right) and increment the bit index.
    - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample on the same rule. parity_err_next = (XOR of the data bits XOR sampled bit XOR PARITY_ODD) != 0. Then -> STOP.
  - STOP: sample on the same rule. frame_err_next = ~rx_s. Then -> IDLE immediately, at mid stop bit, so a start bit following directly is not missed.
- Completion: the completion cycle is the clk cycle in STOP where sample_tick=1 and the sample condition holds.
  - The output registers update on that clock edge, so rx_valid rises 1 clk after the stop-bit sample tick.
  - Total latency from the rx falling edge: about 2 clk of synchronizer plus (1.5 + DATA_BITS + PARITY_EN) bit periods.
  - Frames with frame_err (including a break, all zeros) are still delivered, with frame_err=1.
- Handshake and overrun at completion:
  - rx_valid=0, or rx_valid=1 && rx_ready=1 in the same cycle: load rx_data, frame_err, parity_err; rx_valid=1; no overrun.
  - rx_valid=1 && rx_ready=0: the new frame is discarded. rx_data and the flags keep the old word; overrun=1 for exactly one clk.
  - Without completion, rx_valid && rx_ready clears rx_valid on the next edge. rx_data and the flags hold their last values.
- rx_ready is ignored while rx_valid=0.
- busy=1 in START, DATA, PARITY and STOP. busy does not depend on rx_valid.

Test Plan:
- OVERSAMPLE=16, tick every 4 clk, rx_ready=1, send 0xA5 8N1 -> rx_data=0xA5, frame_err=0, rx_valid high exactly 1 clk, 1 clk after the stop sample tick.
- Low pulse on rx lasting 6 ticks from idle -> FSM returns to IDLE at tick 8, busy falls, no rx_valid, no flags.
- Send 0x3C with the stop bit driven low -> rx_valid=1, rx_data=0x3C, frame_err=1. Then 0x00 with a correct stop -> frame_err=0.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 (wrong) -> parity_err=1; resend with parity 1 -> parity_err=0.
- rx_ready=0, send 0x11 then 0x22 back to back -> rx_data stays 0x11 and overrun pulses 1 clk. Raise rx_ready -> rx_valid drops after 1 clk.
- Assert reset during DATA bit 4 of a frame, release, send 0x5A -> no output from the aborted frame; 0x5A received correctly.
